// File: rtl/lfsr_pkg.sv
// Shared definitions for the 24-bit PRBS generator/checker pair
// (taps 23, 22, 21, 16).
package lfsr_pkg;

   localparam int LFSR_W = 24;
   localparam int TAP_A  = 23;
   localparam int TAP_B  = 22;
   localparam int TAP_C  = 21;
   localparam int TAP_D  = 16;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   // Feedback bit appended at the LSB on every shift; it is also the transmitted bit.
   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] r);
      return r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D];
   endfunction

endpackage

// File: rtl/lfsr_err_window.sv
// Sliding error-rate tracker: counts errors inside consecutive WINDOW-bit
// windows and flags the bit whose error brings the count up to ERR_THRESH.
module lfsr_err_window
   import lfsr_pkg::*;
#(
   parameter int WINDOW     = 64,
   parameter int ERR_THRESH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   input  logic error,
   input  logic clear,
   output logic thresh_hit
);

   localparam int CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
   localparam int EW = $clog2(WINDOW + 1);

   logic [CW-1:0] win_cnt_q, win_cnt_d;
   logic [EW-1:0] win_err_q, win_err_d;
   logic          wrap;

   assign wrap = (win_cnt_q == CW'(WINDOW - 1));

   always_comb begin
      win_cnt_d  = win_cnt_q;
      win_err_d  = win_err_q;
      thresh_hit = 1'b0;
      if (clear) begin
         win_cnt_d = '0;
         win_err_d = '0;
      end else if (strobe) begin
         // WINDOW is a power of two, so the counter wraps to 0 on its own.
         win_cnt_d = win_cnt_q + 1'b1;
         if (wrap) begin
            win_err_d = EW'(error);
         end else begin
            win_err_d = win_err_q + EW'(error);
         end
         thresh_hit = error && (win_err_d == EW'(ERR_THRESH));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt_q <= '0;
         win_err_q <= '0;
      end else begin
         win_cnt_q <= win_cnt_d;
         win_err_q <= win_err_d;
      end
   end

endmodule

// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-synchronises to the 24-bit LFSR stream, declares
// lock after a clean verify run, then counts errors and drops lock on bursts.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int WINDOW     = 64,
   parameter int ERR_THRESH = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             clear_count,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count
);

   localparam int FW = $clog2(LFSR_W);

   chk_state_t        state_q, state_d;
   logic [LFSR_W-1:0] ref_q, ref_d;
   logic [FW-1:0]     fill_cnt_q, fill_cnt_d;
   logic [FW-1:0]     ver_cnt_q, ver_cnt_d;
   logic              err_pulse_q, err_pulse_d;
   logic [CNT_W-1:0]  err_count_q, err_count_d;

   logic pred;
   logic mism;
   logic win_strobe;
   logic win_clear;
   logic thresh_hit;

   assign pred = lfsr_fb(ref_q);
   assign mism = bit_in ^ pred;

   lfsr_err_window #(
      .WINDOW     (WINDOW),
      .ERR_THRESH (ERR_THRESH)
   ) u_window (
      .clk        (clk),
      .rst        (rst),
      .strobe     (win_strobe),
      .error      (mism),
      .clear      (win_clear),
      .thresh_hit (thresh_hit)
   );

   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      fill_cnt_d  = fill_cnt_q;
      ver_cnt_d   = ver_cnt_q;
      err_pulse_d = 1'b0;
      err_count_d = err_count_q;
      win_strobe  = 1'b0;
      win_clear   = 1'b0;

      unique case (state_q)
         HUNT: begin
            if (bit_valid) begin
               ref_d = {ref_q[LFSR_W-2:0], bit_in};
               if (fill_cnt_q == FW'(LFSR_W - 1)) begin
                  // An all-zero register is the LFSR's lock-up state; refill instead.
                  fill_cnt_d = '0;
                  if (ref_d != '0) begin
                     state_d   = VERIFY;
                     ver_cnt_d = '0;
                  end
               end else begin
                  fill_cnt_d = fill_cnt_q + 1'b1;
               end
            end
         end

         VERIFY: begin
            if (bit_valid) begin
               ref_d = {ref_q[LFSR_W-2:0], bit_in};
               if (mism) begin
                  state_d    = HUNT;
                  fill_cnt_d = '0;
               end else if (ver_cnt_q == FW'(LFSR_W - 1)) begin
                  state_d   = LOCKED;
                  ver_cnt_d = '0;
                  win_clear = 1'b1;
               end else begin
                  ver_cnt_d = ver_cnt_q + 1'b1;
               end
            end
         end

         LOCKED: begin
            if (bit_valid) begin
               // Free-run on the prediction so one flipped bit costs one error, not several.
               ref_d       = {ref_q[LFSR_W-2:0], pred};
               win_strobe  = 1'b1;
               err_pulse_d = mism;
               if (mism && (err_count_q != '1)) begin
                  err_count_d = err_count_q + 1'b1;
               end
               if (thresh_hit) begin
                  state_d    = HUNT;
                  fill_cnt_d = '0;
               end
            end
         end

         default: begin
            state_d    = HUNT;
            fill_cnt_d = '0;
         end
      endcase

      if (clear_count) begin
         err_count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HUNT;
         ref_q       <= '0;
         fill_cnt_q  <= '0;
         ver_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         fill_cnt_q  <= fill_cnt_d;
         ver_cnt_q   <= ver_cnt_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = (state_q == LOCKED);
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scenario bench for lfsr_checker against a sequence-level reference model.
module tb_lfsr_checker;

   localparam int WINDOW = 64;
   localparam int THRESH = 8;
   localparam int CNT_W  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             bit_valid;
   logic             bit_in;
   logic             clear_count;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lfsr_checker #(
      .WINDOW     (WINDOW),
      .ERR_THRESH (THRESH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bit_valid   (bit_valid),
      .bit_in      (bit_in),
      .clear_count (clear_count),
      .locked      (locked),
      .err_pulse   (err_pulse),
      .err_count   (err_count)
   );

   // Transmit-side generator
   logic [23:0] gen;

   task automatic gen_bit(output logic b);
      b   = gen[23] ^ gen[22] ^ gen[21] ^ gen[16];
      gen = {gen[22:0], b};
   endtask

   // Reference model in sequence terms: x[n] = x[n-24]^x[n-23]^x[n-22]^x[n-17].
   // hist[0] is the oldest of the last 24 bits.
   bit hist[$];
   int m_state;      // 0 hunt, 1 verify, 2 locked
   int m_fill, m_ver, m_wcnt, m_werr, m_cnt;
   bit m_pulse;

   task automatic model_reset();
      hist.delete();
      repeat (24) hist.push_back(1'b0);
      m_state = 0; m_fill = 0; m_ver = 0; m_wcnt = 0; m_werr = 0; m_cnt = 0; m_pulse = 0;
   endtask

   task automatic model_step(input bit v, input bit b, input bit clr);
      bit p, e, allz;
      m_pulse = 0;
      if (v) begin
         p = hist[0] ^ hist[1] ^ hist[2] ^ hist[7];
         case (m_state)
            0: begin
               hist.push_back(b); void'(hist.pop_front());
               m_fill++;
               if (m_fill == 24) begin
                  m_fill = 0;
                  allz = 1;
                  foreach (hist[i]) if (hist[i]) allz = 0;
                  if (!allz) begin m_state = 1; m_ver = 0; end
               end
            end
            1: begin
               hist.push_back(b); void'(hist.pop_front());
               if (b != p) begin
                  m_state = 0; m_fill = 0;
               end else begin
                  m_ver++;
                  if (m_ver == 24) begin m_state = 2; m_wcnt = 0; m_werr = 0; end
               end
            end
            default: begin
               hist.push_back(p); void'(hist.pop_front());
               e = (b != p);
               m_pulse = e;
               if (e && m_cnt < (1 << CNT_W) - 1) m_cnt++;
               m_wcnt++;
               if (m_wcnt == WINDOW) begin m_wcnt = 0; m_werr = e; end
               else m_werr += e;
               if (e && m_werr == THRESH) begin m_state = 0; m_fill = 0; end
            end
         endcase
      end
      if (clr) m_cnt = 0;
   endtask

   task automatic step(input bit v, input bit b, input bit clr);
      bit_valid = v; bit_in = b; clear_count = clr;
      @(posedge clk);
      model_step(v, b, clr);
      #1;
   endtask

   task automatic send(input bit flip);
      logic b;
      gen_bit(b);
      step(1'b1, b ^ flip, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; bit_valid = 0; bit_in = 0; clear_count = 0;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic lock_up();
      gen = 24'h000001;
      repeat (48) send(1'b0);
   endtask

   task automatic test_reset();
      #1;
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got %b want 0", locked); end
      tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse got %b want 0", err_pulse); end
      tests++; if (err_count !== '0) begin fails++; $display("FAIL reset_count got %0d want 0", err_count); end
   endtask

   task automatic test_clean_lock();
      do_reset();
      gen = 24'h000001;
      for (int i = 1; i <= 48; i++) begin
         send(1'b0);
         tests++;
         if (locked !== (i == 48)) begin fails++; $display("FAIL clean_lock bit %0d got %b want %b", i, locked, i == 48); end
      end
      for (int i = 0; i < 1000; i++) begin
         send(1'b0);
         tests++;
         if (err_count !== '0 || locked !== 1'b1) begin
            fails++; $display("FAIL clean_run bit %0d count %0d locked %b want 0/1", i, err_count, locked);
         end
      end
   endtask

   task automatic test_single_error();
      send(1'b1);
      tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL single_pulse got %b want 1", err_pulse); end
      tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL single_count got %0d want 1", err_count); end
      for (int i = 0; i < 100; i++) begin
         send(1'b0);
         tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL single_after bit %0d pulse %b want 0", i, err_pulse); end
      end
      tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL single_final_count got %0d want 1", err_count); end
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL single_locked got %b want 1", locked); end
   endtask

   task automatic test_threshold();
      do_reset();
      lock_up();
      repeat (2) send(1'b0);
      for (int k = 0; k < 8; k++) begin
         send(1'b1);
         if (k < 7) begin
            tests++; if (locked !== 1'b1) begin fails++; $display("FAIL thresh_hold err %0d locked %b want 1", k + 1, locked); end
            repeat (3) send(1'b0);
         end
      end
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL thresh_drop locked %b want 0", locked); end
      tests++; if (err_count !== 16'd8) begin fails++; $display("FAIL thresh_count got %0d want 8", err_count); end
      tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL thresh_pulse got %b want 1", err_pulse); end
      for (int i = 1; i <= 48; i++) begin
         send(1'b0);
         tests++;
         if (locked !== (i == 48)) begin fails++; $display("FAIL thresh_relock bit %0d got %b want %b", i, locked, i == 48); end
      end
   endtask

   task automatic test_window_reset();
      bit flip;
      do_reset();
      lock_up();
      for (int i = 1; i <= 128; i++) begin
         flip = (i % 4 == 0) && ((i <= 28) || (i >= 68 && i <= 92));
         send(flip);
      end
      tests++; if (locked !== 1'b1) begin fails++; $display("FAIL window_locked got %b want 1", locked); end
      tests++; if (err_count !== 16'd14) begin fails++; $display("FAIL window_count got %0d want 14", err_count); end
   endtask

   task automatic test_zeros_and_gaps();
      int vcnt, cyc;
      logic b;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b0, 1'b0);
         tests++; if (locked !== 1'b0) begin fails++; $display("FAIL zeros_locked bit %0d got %b want 0", i, locked); end
      end
      do_reset();
      gen = 24'h000001; vcnt = 0; cyc = 0;
      while (vcnt < 48 && cyc < 1000) begin
         cyc++;
         if ($urandom_range(0, 2) != 0) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
            vcnt++;
            tests++;
            if (locked !== (vcnt == 48)) begin fails++; $display("FAIL gap_lock valid %0d got %b want %b", vcnt, locked, vcnt == 48); end
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            tests++;
            if (locked !== 1'b0 || err_pulse !== 1'b0) begin
               fails++; $display("FAIL gap_idle valid %0d locked %b pulse %b want 0/0", vcnt, locked, err_pulse);
            end
         end
      end
      tests++; if (vcnt != 48) begin fails++; $display("FAIL gap_budget valid %0d want 48", vcnt); end
   endtask

   task automatic test_reset_and_clear();
      do_reset();
      lock_up();
      for (int k = 0; k < 5; k++) begin
         repeat (4) send(1'b0);
         send(1'b1);
      end
      tests++; if (err_count !== 16'd5 || err_pulse !== 1'b1) begin
         fails++; $display("FAIL pre_reset count %0d pulse %b want 5/1", err_count, err_pulse);
      end
      rst = 1'b1;
      #1;
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL async_locked got %b want 0", locked); end
      tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL async_pulse got %b want 0", err_pulse); end
      tests++; if (err_count !== '0) begin fails++; $display("FAIL async_count got %0d want 0", err_count); end
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      gen = 24'h000001;
      for (int i = 1; i <= 48; i++) begin
         send(1'b0);
         tests++;
         if (locked !== (i == 48)) begin fails++; $display("FAIL post_reset_lock bit %0d got %b want %b", i, locked, i == 48); end
      end
      send(1'b1);
      tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL clear_pre got %0d want 1", err_count); end
      begin
         logic b;
         gen_bit(b);
         step(1'b1, ~b, 1'b1);
      end
      tests++; if (err_count !== '0 || err_pulse !== 1'b1) begin
         fails++; $display("FAIL clear_vs_err count %0d pulse %b want 0/1", err_count, err_pulse);
      end
      send(1'b1);
      step(1'b0, 1'b0, 1'b1);
      tests++; if (err_count !== '0) begin fails++; $display("FAIL clear_idle got %0d want 0", err_count); end
   endtask

   task automatic test_random();
      logic b;
      bit v, flip, clr;
      int rate;
      do_reset();
      gen = 24'h000001;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         rate = ((cyc / 500) % 2) ? 5 : 60;
         v    = ($urandom_range(0, 3) != 0);
         flip = ($urandom_range(0, rate) == 0);
         clr  = ($urandom_range(0, 199) == 0);
         if (v) begin
            gen_bit(b);
            step(1'b1, b ^ flip, clr);
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)), clr);
         end
         tests++;
         if (locked !== (m_state == 2) || err_pulse !== m_pulse || err_count !== CNT_W'(m_cnt)) begin
            fails++;
            $display("FAIL random cyc %0d got locked %b pulse %b count %0d want %b %b %0d",
                     cyc, locked, err_pulse, err_count, m_state == 2, m_pulse, m_cnt);
         end
      end
   endtask

   initial begin
      rst = 1'b1; bit_valid = 0; bit_in = 0; clear_count = 0;
      model_reset();
      test_reset();
      test_clean_lock();
      test_single_error();
      test_threshold();
      test_window_reset();
      test_zeros_and_gaps();
      test_reset_and_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
